riscv_muldiv_unit: RTL and testbench
====================================

Name: riscv_muldiv_unit

Overview:
- Stand-alone iterative RISC-V M-extension unit (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) with XLEN-generic datapath and configurable multiply bits per cycle.
- Decoupled from the integer ALU by valid/ready handshakes on input and output, so the pipeline stalls on `in_ready` / `out_valid` and no longer depends on a combinational wait flag.
- Supports flush (kill on branch or trap) and applies the exact RISC-V divide-by-zero and overflow results.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_BITS, 2, multiplier bits consumed per multiply iteration; legal values 1, 2, 4.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  M-extension op code: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- rs1  in  XLEN  first operand: multiplicand / dividend.
- rs2  in  XLEN  second operand: multiplier / divisor.
- flush  in  1  abandon the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  result; 0 whenever out_valid=0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, out_valid=0, out_result=0; all datapath registers 0.
  - in_ready=1 once reset_n is released.
- States: IDLE, MUL, DIV, DONE. `in_ready = (state==IDLE)`; there is no overlap of operations.
- IDLE, on accept (in_valid & in_ready & !flush):
  - Latch funct3, the result sign and the remainder sign (= sign of rs1).
  - Latch operand magnitudes:
    - signed ops negate negative operands;
    - mulhsu negates rs1 only;
    - unsigned ops pass operands unchanged.
  - Special cases go straight to DONE, so the result is valid the next cycle (latency 1):
    - div/divu with rs2==0: quotient = all ones.
    - rem/remu with rs2==0: remainder = rs1.
    - div with rs1 = -2^(XLEN-1) and rs2 = -1: quotient = rs1; rem for the same operands = 0.
    - Any op with rs1==0, and mul* with rs2==0: result 0.
  - Otherwise go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- MUL:
  - Each cycle: add the partial product of the low MUL_BITS multiplier bits to a 2*XLEN accumulator, shift the multiplicand left by MUL_BITS, shift the multiplier right by MUL_BITS.
  - Exit to DONE when the shifted multiplier is 0 (early termination).
  - Worst-case accept-to-out_valid latency: ceil(XLEN/MUL_BITS)+1 cycles.
- DIV:
  - Restoring division, 1 quotient bit per cycle.
  - Start bit index = top bit of the most-significant nonzero byte of the dividend magnitude.
  - Exit when bit index 0 has been processed. Worst case XLEN+1 cycles.
- Sign fix-up is applied on the transition into DONE:
  - mul low half, or high half per funct3;
  - mulhsu negates the full 2*XLEN product when rs1<0;
  - quotient negated when result sign=1;
  - remainder negated when remainder sign=1.
- DONE:
  - out_valid=1, out_result held stable until out_ready=1; then IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- flush:
  - In any state: next cycle state=IDLE and out_valid=0; the result is discarded.
  - flush together with in_valid in IDLE: the request is not accepted.
  - flush has priority over out_ready in DONE.
- Inputs rs1/rs2/funct3 are ignored outside the accept cycle.

Optional Feature:
- Macro: MULDIV_REUSE_EN
- With the macro defined:
  - Every completed division stores the quotient, remainder, rs1, rs2 and signedness in a reuse register.
  - A div/rem (same signedness) whose operands match the stored ones goes IDLE -> DONE, so latency is 1.
  - reset, flush and any multiply invalidate the reuse register.
- Without the macro: no reuse register; every division iterates.

Test Plan (XLEN=32, MUL_BITS=2):
1. mul rs1=7, rs2=0xFFFFFFFD -> out_result=0xFFFFFFEB; mulh with the same operands -> 0xFFFFFFFF; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF*2 -> 0xFFFFFFFF.
2. div 20/0 -> 0xFFFFFFFF, and remu 20/0 -> 20; in both cases out_valid is high the cycle after accept.
3. div 0x80000000/0xFFFFFFFF -> 0x80000000; rem with the same operands -> 0; both have latency 1.
4. rem 0xFFFFFFF9/2 -> 0xFFFFFFFF; divu 100/7 -> 14 with out_ready held low 3 cycles -> out_result stable and out_valid high throughout, in_ready=0 until the handshake.
5. flush asserted 5 cycles into divu 0xFFFFFFFF/3 -> out_valid never rises, in_ready=1 next cycle; then reset_n pulsed low mid-mul -> out_valid=0 and out_result=0 immediately.
6. With MULDIV_REUSE_EN: divu 100/7, then remu 100/7 -> 2 with latency 1; an intervening mul, or a flush, restores the full iterative latency.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2^MUL_BITS early-exit multiplier, restoring divider.
// Optional MULDIV_REUSE_EN keeps the last division result for back-to-back div/rem on equal operands.
module riscv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int IDXW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       dvd_q, dvd_d;
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       quo_q, quo_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [XLEN-1:0]       result_q, result_d;
`ifdef MULDIV_REUSE_EN
  logic                  reuse_vld_q, reuse_vld_d;
  logic                  reuse_sgn_q, reuse_sgn_d;
  logic [XLEN-1:0]       reuse_rs1_q, reuse_rs1_d;
  logic [XLEN-1:0]       reuse_rs2_q, reuse_rs2_d;
  logic [XLEN-1:0]       reuse_quo_q, reuse_quo_d;
  logic [XLEN-1:0]       reuse_rem_q, reuse_rem_d;
  logic [XLEN-1:0]       op_rs1_q, op_rs1_d;
  logic [XLEN-1:0]       op_rs2_q, op_rs2_d;
`endif

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   sgn1, sgn2, a_neg, b_neg;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic [2*XLEN-1:0]      pp, prod;
  logic [XLEN-1:0]        mplier_sh;
  logic [XLEN:0]          rem_sh;
  logic                   div_ge;
  logic [XLEN-1:0]        rem_nxt, quo_nxt, quo_fix, rem_fix;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Magnitude product back to a signed result; mul takes the low half, mulh* the high half.
  function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] p, input logic neg,
                                              input logic hi);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
  endfunction

  // Skip leading zero bytes of the dividend so small dividends finish early.
  function automatic logic [IDXW-1:0] start_idx(input logic [XLEN-1:0] v);
    logic [IDXW-1:0] idx;
    idx = IDXW'(7);
    for (int b = 0; b < XLEN / 8; b++)
      if (v[b*8 +: 8] != 8'd0) idx = IDXW'(b * 8 + 7);
    return idx;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    idx_d     = idx_q;
    result_d  = result_q;
`ifdef MULDIV_REUSE_EN
    reuse_vld_d = reuse_vld_q;
    reuse_sgn_d = reuse_sgn_q;
    reuse_rs1_d = reuse_rs1_q;
    reuse_rs2_d = reuse_rs2_q;
    reuse_quo_d = reuse_quo_q;
    reuse_rem_d = reuse_rem_q;
    op_rs1_d    = op_rs1_q;
    op_rs2_d    = op_rs2_q;
`endif

    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    out_result = out_valid ? result_q : '0;

    // rs1 is signed for mul/mulh/mulhsu/div/rem, rs2 for mul/mulh/div/rem.
    sgn1  = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
            (funct3 == 3'd4) || (funct3 == 3'd6);
    sgn2  = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg = sgn1 && (rs1_s < 0);
    b_neg = sgn2 && (rs2_s < 0);
    a_mag = cond_neg(rs1, a_neg);
    b_mag = cond_neg(rs2, b_neg);

    pp = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    prod      = acc_q + pp;
    mplier_sh = mplier_q >> MUL_BITS;

    rem_sh  = {rem_q, dvd_q[idx_q]};
    div_ge  = rem_sh >= {1'b0, dvs_q};
    rem_nxt = div_ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], div_ge};
    quo_fix = cond_neg(quo_nxt, neg_res_q);
    rem_fix = cond_neg(rem_nxt, neg_rem_q);

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d      = funct3;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          mcand_d   = {{XLEN{1'b0}}, a_mag};
          mplier_d  = b_mag;
          acc_d     = '0;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = '0;
          quo_d     = '0;
          idx_d     = start_idx(a_mag);
`ifdef MULDIV_REUSE_EN
          op_rs1_d = rs1;
          op_rs2_d = rs2;
          if (!funct3[2]) reuse_vld_d = 1'b0;
`endif
          state_d = DONE;
          if (funct3[2] && rs2 == '0)
            result_d = funct3[1] ? rs1 : '1;
          else if (sgn2 && funct3[2] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1)
            result_d = funct3[1] ? '0 : rs1;
          else if (rs1 == '0 || rs2 == '0)
            result_d = '0;
`ifdef MULDIV_REUSE_EN
          else if (funct3[2] && reuse_vld_q && reuse_sgn_q == !funct3[0] &&
                   reuse_rs1_q == rs1 && reuse_rs2_q == rs2)
            result_d = funct3[1] ? reuse_rem_q : reuse_quo_q;
`endif
          else
            state_d = funct3[2] ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_sh;
        if (mplier_sh == '0) begin
          result_d = mul_fix(prod, neg_res_q, op_q != 3'd0);
          state_d  = DONE;
        end
      end
      DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = DONE;
`ifdef MULDIV_REUSE_EN
          reuse_vld_d = 1'b1;
          reuse_sgn_d = !op_q[0];
          reuse_rs1_d = op_rs1_q;
          reuse_rs2_d = op_rs2_q;
          reuse_quo_d = quo_fix;
          reuse_rem_d = rem_fix;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
`ifdef MULDIV_REUSE_EN
      reuse_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      idx_q     <= '0;
      result_q  <= '0;
`ifdef MULDIV_REUSE_EN
      reuse_vld_q <= 1'b0;
      reuse_sgn_q <= 1'b0;
      reuse_rs1_q <= '0;
      reuse_rs2_q <= '0;
      reuse_quo_q <= '0;
      reuse_rem_q <= '0;
      op_rs1_q    <= '0;
      op_rs2_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
`ifdef MULDIV_REUSE_EN
      reuse_vld_q <= reuse_vld_d;
      reuse_sgn_q <= reuse_sgn_d;
      reuse_rs1_q <= reuse_rs1_d;
      reuse_rs2_q <= reuse_rs2_d;
      reuse_quo_q <= reuse_quo_d;
      reuse_rem_q <= reuse_rem_d;
      op_rs1_q    <= op_rs1_d;
      op_rs2_q    <= op_rs2_d;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit (XLEN=32, MUL_BITS=2); MULDIV_REUSE_EN selects the reuse expectations.
module tb_riscv_muldiv_unit;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int checks   = 0;
  int failures = 0;

  riscv_muldiv_unit #(.XLEN(32), .MUL_BITS(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one request and wait for out_valid; lat counts edges from accept to out_valid.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output int lat);
    check({tag, "_in_ready"}, in_ready, 1);
    funct3   = f;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    funct3   = 3'd0;
    rs1      = 32'hDEAD_BEEF;
    rs2      = 32'h1234_5678;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int lat;
    start_op(f, a, b, tag, lat);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_latency"}, lat, exp_lat);
    consume();
  endtask

  initial begin
    int lat;
    int seen;
    clock     = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    funct3    = 3'd0;
    rs1       = '0;
    rs2       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    #11 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul_7_m3");
    run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, "mulh_7_m3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2, "mulhsu_m1_2");
    run_op(3'd0, 32'd5, 32'd0, 32'd0, 1, "mul_by_zero");

    run_op(3'd4, 32'd20, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
    run_op(3'd7, 32'd20, 32'd0, 32'd20, 1, "remu_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    run_op(3'd5, 32'd0, 32'd5, 32'd0, 1, "divu_zero_dividend");

    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 9, "rem_m7_2");
    run_op(3'd4, 32'hFFFF_FFF3, 32'd2, 32'hFFFF_FFFA, 9, "div_m13_2");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, "divu_worst");

    // Result held while the consumer stalls.
    start_op(3'd5, 32'd100, 32'd7, "hold", lat);
    check("hold_result", out_result, 14);
    check("hold_latency", lat, 9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_out_result", out_result, 14);
      check("hold_in_ready", in_ready, 0);
    end
    consume();
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_out_result", out_result, 0);

    // Flush in the middle of a long division.
    funct3   = 3'd5;
    rs1      = 32'hFFFF_FFFF;
    rs2      = 32'd3;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("flush_busy", in_ready, 0);
    repeat (4) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 0);

    // Flush together with a request in IDLE: nothing is accepted.
    funct3   = 3'd0;
    rs1      = 32'd3;
    rs2      = 32'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_req_in_ready", in_ready, 1);
    check("flush_req_out_valid", out_valid, 0);

`ifdef MULDIV_REUSE_EN
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 9, "reuse_divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 1, "reuse_remu_hit");
    run_op(3'd0, 32'd3, 32'd3, 32'd9, 2, "reuse_mul");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 9, "reuse_after_mul");
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 9, "reuse_after_flush");
`else
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 9, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 9, "remu_100_7");
`endif

    // Asynchronous reset during a multiply.
    funct3   = 3'd3;
    rs1      = 32'hFFFF_FFFF;
    rs2      = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("mid_mul_in_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mul_out_valid", out_valid, 0);
    check("rst_mul_out_result", out_result, 0);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mul_in_ready", in_ready, 1);

    // Asynchronous reset while a result is pending.
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD, "rst_done", lat);
    check("rst_done_result", out_result, 32'hFFFF_FFEB);
    reset_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_out_result", out_result, 0);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_done_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
